// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: FSM encoding and BCD constants.
package bcd_stopwatch_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_LAP   = 2'd2;
   localparam logic [1:0] ST_PAUSE = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      LAP   = ST_LAP,
      PAUSE = ST_PAUSE
   } state_t;

   localparam logic [3:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_stopwatch_ctrl_tick_prescaler.sv
// Free-running divide-by-DIV prescaler; tick marks the cycle the count sits at DIV-1
// while running, so the wrap and the tick coincide.
module tick_prescaler #(
   parameter int DIV = 100000,
   parameter int PW  = $clog2(DIV)
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic tick
);

   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] count;

   assign tick = run && (count == LAST);

   // Holding (not clearing) when run drops lets a paused stopwatch resume mid-period.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (run) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/lap/clear controller for a cascaded BCD counter.
// Optional: define BCD_STOP_ON_OVF_EN to freeze at all-nines instead of wrapping.
module bcd_stopwatch_ctrl
   import bcd_stopwatch_ctrl_pkg::*;
#(
   parameter int Ndigit = 3,
   parameter int DIV    = 100000,
   parameter int PW     = $clog2(DIV)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_stop,
   input  logic                  lap,
   input  logic                  clear,
   input  logic [Ndigit*4-1:0]   bcd_in,
   output logic                  cnt_en,
   output logic                  cnt_clr,
   output logic [Ndigit*4-1:0]   disp_bcd,
   output logic                  running,
   output logic                  ovf
);

   state_t state, state_next;
   logic [Ndigit*4-1:0] snapshot;
   logic [Ndigit-1:0]   digit_nine;
   logic all_nines, active, presc_run, presc_clr, tick, ovf_stop;

   for (genvar d = 0; d < Ndigit; d++) begin : g_nine
      assign digit_nine[d] = (bcd_in[d*4 +: 4] == BCD_NINE);
   end
   assign all_nines = &digit_nine;

   // A start_stop or clear in the wrap cycle freezes the prescaler before the tick lands.
   assign active    = (state == RUN) || (state == LAP);
   assign presc_run = active && !start_stop && !clear;
   assign presc_clr = clear || (state == IDLE);

   tick_prescaler #(.DIV(DIV), .PW(PW)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .run  (presc_run),
      .clr  (presc_clr),
      .tick (tick)
   );

`ifdef BCD_STOP_ON_OVF_EN
   assign ovf_stop = tick && all_nines;
`else
   assign ovf_stop = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = IDLE;
      end else if (start_stop) begin
         case (state)
            IDLE:    state_next = RUN;
            RUN:     state_next = PAUSE;
            LAP:     state_next = PAUSE;
`ifdef BCD_STOP_ON_OVF_EN
            PAUSE:   state_next = ovf ? PAUSE : RUN;
`else
            PAUSE:   state_next = RUN;
`endif
            default: state_next = IDLE;
         endcase
      end else if (ovf_stop) begin
         state_next = PAUSE;
      end else if (lap) begin
         if (state == RUN)      state_next = LAP;
         else if (state == LAP) state_next = RUN;
      end
   end

   always_comb begin
      disp_bcd = (state == LAP) ? snapshot : bcd_in;
   end

   // Overflow is judged on the cycle cnt_en is presented, when bcd_in still shows the pre-wrap value.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_en   <= 1'b0;
         cnt_clr  <= 1'b0;
         ovf      <= 1'b0;
         running  <= 1'b0;
         snapshot <= '0;
      end else begin
         cnt_en  <= tick && !ovf_stop;
         cnt_clr <= clear;
         running <= (state_next == RUN) || (state_next == LAP);
         if (clear)
            ovf <= 1'b0;
         else if (ovf_stop || (cnt_en && all_nines))
            ovf <= 1'b1;
         if (state == RUN && state_next == LAP)
            snapshot <= bcd_in;
      end
   end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench for bcd_stopwatch_ctrl with a behavioural BCD counter attached.
// Honours BCD_STOP_ON_OVF_EN in its reference model when defined.
module tb_bcd_stopwatch_ctrl;

   localparam int ND   = 2;
   localparam int DIV  = 4;
   localparam int W    = ND * 4;
   localparam int MODN = 100;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_LAP   = 2;
   localparam int M_PAUSE = 3;

   logic clk = 1'b0;
   logic rst, start_stop, lap, clear;
   logic [W-1:0] bcd_in, disp_bcd;
   logic cnt_en, cnt_clr, running, ovf;

   always #5 clk = ~clk;

   bcd_stopwatch_ctrl #(.Ndigit(ND), .DIV(DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_stop (start_stop),
      .lap        (lap),
      .clear      (clear),
      .bcd_in     (bcd_in),
      .cnt_en     (cnt_en),
      .cnt_clr    (cnt_clr),
      .disp_bcd   (disp_bcd),
      .running    (running),
      .ovf        (ovf)
   );

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < ND; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Attached counter: a plain decimal integer, shown to the DUT as BCD.
   int cnt_val = 0;
   assign bcd_in = to_bcd(cnt_val);
   always @(posedge clk) begin
      if (rst)          cnt_val <= 0;
      else if (cnt_clr) cnt_val <= 0;
      else if (cnt_en)  cnt_val <= (cnt_val + 1) % MODN;
   end

   int edge_no = 0;
   always @(posedge clk) edge_no <= edge_no + 1;

   typedef struct {
      int edge_at;
      bit is_clr;
      int value;
   } pulse_t;
   pulse_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: stopwatch mode, cycles of running toward the next count,
   // pulses presented after the edge, sticky overflow, counter value and lap value.
   int m_mode = M_IDLE, m_phase = 0, m_count = 0, m_snap = 0;
   bit m_en = 0, m_clr = 0, m_ovf = 0;
   bit e_running = 0, e_ovf = 0;
   int e_disp = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edge_no, act, exp);
      end
   endtask

   task automatic modelStep(input bit rs, input bit ss, input bit lp, input bit cl);
      int nc;
      bit active;
      if (rs) begin
         nc = 0;
         m_mode = M_IDLE; m_phase = 0; m_en = 0; m_clr = 0; m_ovf = 0; m_snap = 0;
      end else begin
         nc = m_clr ? 0 : (m_en ? (m_count + 1) % MODN : m_count);
         active = (m_mode == M_RUN) || (m_mode == M_LAP);
         if (cl) begin
            m_mode = M_IDLE; m_phase = 0; m_en = 0; m_clr = 1; m_ovf = 0;
         end else begin
            if (m_en && m_count == MODN - 1) m_ovf = 1;
            m_en = 0;
            m_clr = 0;
            if (ss) begin
               if (m_mode == M_IDLE)       m_mode = M_RUN;
               else if (active)            m_mode = M_PAUSE;
`ifdef BCD_STOP_ON_OVF_EN
               else if (!m_ovf)            m_mode = M_RUN;
`else
               else                        m_mode = M_RUN;
`endif
            end else if (active) begin
               if (m_phase == DIV - 1) begin
                  m_phase = 0;
`ifdef BCD_STOP_ON_OVF_EN
                  if (m_count == MODN - 1) begin
                     m_ovf = 1;
                     m_mode = M_PAUSE;
                  end else begin
                     m_en = 1;
                  end
`else
                  m_en = 1;
`endif
               end else begin
                  m_phase++;
               end
               if (lp && m_mode == M_RUN) begin
                  m_mode = M_LAP;
                  m_snap = m_count;
               end else if (lp && m_mode == M_LAP) begin
                  m_mode = M_RUN;
               end
            end
         end
      end
      m_count = nc;
      if (m_en || m_clr) sb.push_back('{edge_no + 1, m_clr, m_count});
      e_running = (m_mode == M_RUN) || (m_mode == M_LAP);
      e_ovf     = m_ovf;
      e_disp    = (m_mode == M_LAP) ? m_snap : m_count;
   endtask

   task automatic applyStimulus(input bit rs, input bit ss, input bit lp, input bit cl);
      rst = rs; start_stop = ss; lap = lp; clear = cl;
      modelStep(rs, ss, lp, cl);
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
   endtask

   // Monitor: status every cycle, and each count/clear pulse against the scoreboard.
   initial begin
      pulse_t p;
      forever begin
         @(posedge clk);
         #2;
         checkOutput("running", running, e_running);
         checkOutput("ovf", ovf, e_ovf);
         checkOutput("disp_bcd", disp_bcd, to_bcd(e_disp));
         while (sb.size() > 0 && sb[0].edge_at < edge_no) begin
            p = sb.pop_front();
            checkOutput("missed_pulse_edge", edge_no, p.edge_at);
         end
         if (cnt_en || cnt_clr) begin
            if (sb.size() == 0) begin
               checkOutput("spurious_pulse", {cnt_en, cnt_clr}, 0);
            end else begin
               p = sb.pop_front();
               checkOutput("pulse_edge", edge_no, p.edge_at);
               checkOutput("pulse_clr", cnt_clr, p.is_clr);
               checkOutput("pulse_en", cnt_en, !p.is_clr);
               checkOutput("pulse_bcd", bcd_in, to_bcd(p.value));
            end
         end
      end
   end

   initial begin
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      idleCycles(3);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0);
      idleCycles(22);
      applyStimulus(0, 0, 1, 0);
      idleCycles(10);
      applyStimulus(0, 0, 1, 0);
      idleCycles(5);
      applyStimulus(0, 1, 0, 0);
      idleCycles(20);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0);
      idleCycles(420);
      applyStimulus(0, 1, 0, 0);
      idleCycles(10);
      applyStimulus(0, 1, 0, 0);
      idleCycles(10);
      applyStimulus(0, 1, 0, 1);
      idleCycles(5);
      applyStimulus(0, 1, 0, 0);
      idleCycles(9);
      applyStimulus(0, 0, 1, 0);
      idleCycles(3);
      applyStimulus(1, 0, 0, 0);
      idleCycles(4);
      for (int i = 0; i < 6000; i++) begin
         applyStimulus($urandom_range(0, 1999) == 0,
                       $urandom_range(0, 49) == 0,
                       $urandom_range(0, 24) == 0,
                       $urandom_range(0, 399) == 0);
      end
      idleCycles(6);
      @(posedge clk);
      #3;
      checkOutput("queue_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
